// File: rtl/zeroriscy_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// zeroriscy_rf_wb_arbiter
//
// Arbitrates the single write port of the flip-flop register file between the
// EX-stage result path and the LSU load-return path. It also keeps a
// per-register pending-load scoreboard.
//
// Priority on the write port is LSU > held EX > direct EX. LSU returns are
// never back-pressured. An EX write that is accepted in a cycle where the LSU
// owns the port parks in a one-entry holding register. It drains in the first
// cycle with no LSU return.
//
// The scoreboard flags RAW hazards on the two decode read addresses. It also
// blocks an EX write to a register that still has a load outstanding, so a
// later EX result cannot be overwritten by an older load (WAW).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid_i/waddr/wdata EX write request; ex_ready_o = accepted this cycle
//   lsu_valid_i/waddr/wdata load data return (always accepted)
//   load_issue_i/addr     load issued this cycle, sets the pending bit
//   raddr_a_i, raddr_b_i  decode read addresses checked for hazards
//   hazard_o              a read address is pending or sitting in the hold
//   rf_we_o/waddr/wdata   register file write port
//   busy_o                hold register full or any load outstanding
// ---------------------------------------------------------------------------
module zeroriscy_rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter bit RV32E      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ex_valid_i,
    input  logic [4:0]            ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    output logic                  ex_ready_o,

    input  logic                  lsu_valid_i,
    input  logic [4:0]            lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,

    input  logic                  load_issue_i,
    input  logic [4:0]            load_issue_addr_i,

    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    output logic                  hazard_o,

    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,

    output logic                  busy_o
);

    // RV32E has only 16 registers, so addr[4] is dropped everywhere.
    localparam int IDX_W = RV32E ? 4 : 5;
    localparam int NUM   = 1 << IDX_W;

    function automatic logic [IDX_W-1:0] f_idx(input logic [4:0] addr);
        return addr[IDX_W-1:0];
    endfunction

    logic                  r_hold_valid;
    logic [4:0]            r_hold_addr;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [NUM-1:0]        r_pend;

    logic                  w_ex_acc;
    logic                  w_sel_valid;
    logic [4:0]            w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM-1:0]        w_pend_nxt;
    logic [IDX_W-1:0]      w_idx_a;
    logic [IDX_W-1:0]      w_idx_b;
    logic [IDX_W-1:0]      w_idx_hold;
    logic                  w_haz_a;
    logic                  w_haz_b;

    // While the hold is occupied no new EX write is taken. This keeps the
    // drain and a fresh EX write from ever competing for the same cycle.
    assign w_ex_acc   = ex_valid_i & ~r_hold_valid & ~r_pend[f_idx(ex_waddr_i)];
    assign ex_ready_o = w_ex_acc;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        if (lsu_valid_i) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = lsu_waddr_i;
            w_sel_data  = lsu_wdata_i;
        end else if (r_hold_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = r_hold_addr;
            w_sel_data  = r_hold_data;
        end else if (w_ex_acc) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = ex_waddr_i;
            w_sel_data  = ex_wdata_i;
        end
    end

    // x0 writes still complete the handshake but never reach the file.
    assign rf_we_o    = w_sel_valid & (f_idx(w_sel_addr) != '0);
    assign rf_waddr_o = w_sel_addr;
    assign rf_wdata_o = w_sel_data;

    // The clear is applied first so that a same-cycle issue to the same
    // register wins: the new load is still in flight.
    always_comb begin
        w_pend_nxt = r_pend;
        if (lsu_valid_i) begin
            w_pend_nxt[f_idx(lsu_waddr_i)] = 1'b0;
        end
        if (load_issue_i && (f_idx(load_issue_addr_i) != '0)) begin
            w_pend_nxt[f_idx(load_issue_addr_i)] = 1'b1;
        end
    end

    // A held write has not reached the file yet, so it is a hazard as well.
    // The hazard depends only on state and read addresses, never on ex_*.
    assign w_idx_a    = f_idx(raddr_a_i);
    assign w_idx_b    = f_idx(raddr_b_i);
    assign w_idx_hold = f_idx(r_hold_addr);
    assign w_haz_a    = (w_idx_a != '0) &
                        (r_pend[w_idx_a] | (r_hold_valid & (w_idx_hold == w_idx_a)));
    assign w_haz_b    = (w_idx_b != '0) &
                        (r_pend[w_idx_b] | (r_hold_valid & (w_idx_hold == w_idx_b)));
    assign hazard_o   = w_haz_a | w_haz_b;

    assign busy_o = r_hold_valid | (|r_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_pend       <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            // Capture EX only when the LSU took the port in the same cycle.
            if (w_ex_acc && lsu_valid_i) begin
                r_hold_valid <= 1'b1;
                r_hold_addr  <= ex_waddr_i;
                r_hold_data  <= ex_wdata_i;
            end else if (r_hold_valid && !lsu_valid_i) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_rf_wb_arbiter.sv
module tb_zeroriscy_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        load_issue_i;
    logic [4:0]  load_issue_addr_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;

    logic        ex_ready_o, hazard_o, rf_we_o, busy_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    logic        ex_ready_e, hazard_e, rf_we_e, busy_e;
    logic [4:0]  rf_waddr_e;
    logic [31:0] rf_wdata_e;

    int total;
    int bad;

    zeroriscy_rf_wb_arbiter #(.DATA_WIDTH(32), .RV32E(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .load_issue_i(load_issue_i), .load_issue_addr_i(load_issue_addr_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_o(hazard_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .busy_o(busy_o)
    );

    zeroriscy_rf_wb_arbiter #(.DATA_WIDTH(32), .RV32E(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_e),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .load_issue_i(load_issue_i), .load_issue_addr_i(load_issue_addr_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_o(hazard_e),
        .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e),
        .busy_o(busy_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exv;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        li;
        logic [4:0]  lia;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_rdy;
        logic        e_haz;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic exv, input logic [4:0] exa, input logic [31:0] exd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic li, input logic [4:0] lia,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic e_rdy, input logic e_haz, input logic e_we,
        input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_busy);
        vec_t v;
        v.exv = exv; v.exa = exa; v.exd = exd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.li = li; v.lia = lia; v.ra = ra; v.rb = rb;
        v.e_rdy = e_rdy; v.e_haz = e_haz; v.e_we = e_we;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic exv, input logic [4:0] exa, input logic [31:0] exd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic li, input logic [4:0] lia,
                         input logic [4:0] ra, input logic [4:0] rb);
        ex_valid_i = exv; ex_waddr_i = exa; ex_wdata_i = exd;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
        load_issue_i = li; load_issue_addr_i = lia;
        raddr_a_i = ra; raddr_b_i = rb;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #12;
        chk("rst_ex_ready", {31'b0, ex_ready_o}, 32'd0);
        chk("rst_hazard",   {31'b0, hazard_o},   32'd0);
        chk("rst_we",       {31'b0, rf_we_o},    32'd0);
        chk("rst_waddr",    {27'b0, rf_waddr_o}, 32'd0);
        chk("rst_wdata",    rf_wdata_o,          32'd0);
        chk("rst_busy",     {31'b0, busy_o},     32'd0);
        rst_n = 1'b1;

        //            exv exa  exd          lv la  ld           li lia ra rb   rdy haz we wa  wd           busy
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(1, 5, 32'h12345678, 0, 0, 0,            0, 0, 0, 0,   1, 0, 1, 5, 32'h12345678, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0, 0,            0));
        // EX collides with LSU: LSU wins, EX is held and drains next cycle
        vecs.push_back(mk(1, 6, 32'hAAAA0001, 1, 7, 32'h55550002, 0, 0, 0, 0,   1, 0, 1, 7, 32'h55550002, 0));
        vecs.push_back(mk(1, 8, 32'h11,       0, 0, 0,            0, 0, 0, 0,   0, 0, 1, 6, 32'hAAAA0001, 1));
        vecs.push_back(mk(1, 8, 32'h11,       0, 0, 0,            0, 0, 0, 0,   1, 0, 1, 8, 32'h11,       0));
        // Load to x9: hazard from next cycle, EX to x9 stalled until return
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9, 9, 0,   0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(1, 9, 32'h99,       0, 0, 0,            0, 0, 9, 0,   0, 1, 0, 0, 0,            1));
        vecs.push_back(mk(1, 9, 32'h99,       1, 9, 32'hDEADBEEF, 0, 0, 9, 0,   0, 1, 1, 9, 32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 9, 32'h99,       0, 0, 0,            0, 0, 9, 0,   1, 0, 1, 9, 32'h99,       0));
        // Issue and return to x3 in the same cycle: pend stays set
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 3, 0, 3,   0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0,            1, 3, 32'h333,      1, 3, 0, 3,   0, 1, 1, 3, 32'h333,      1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 3,   0, 1, 0, 0, 0,            1));
        vecs.push_back(mk(0, 0, 0,            1, 3, 32'h444,      0, 0, 0, 3,   0, 1, 1, 3, 32'h444,      1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 3,   0, 0, 0, 0, 0,            0));
        // x0: accepted, never written, never pending, never hazardous
        vecs.push_back(mk(1, 0, 32'h5,        0, 0, 0,            1, 0, 0, 0,   1, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(1, 0, 32'h7,        1, 10, 32'hA,       0, 0, 0, 0,   1, 0, 1, 10, 32'hA,       0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0, 0,            1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0, 0,            0));
        // LSU return to a non-pending register
        vecs.push_back(mk(0, 0, 0,            1, 12, 32'hC,       0, 0, 0, 0,   0, 0, 1, 12, 32'hC,       0));
        // Back-to-back LSU returns starve the hold; held x13 is a hazard
        vecs.push_back(mk(1, 13, 32'hD13,     1, 14, 32'hE14,     0, 0, 0, 13,  1, 0, 1, 14, 32'hE14,     0));
        vecs.push_back(mk(1, 16, 32'h16,      1, 15, 32'hF15,     0, 0, 0, 13,  0, 1, 1, 15, 32'hF15,     1));
        vecs.push_back(mk(1, 16, 32'h16,      1, 17, 32'h17,      0, 0, 0, 13,  0, 1, 1, 17, 32'h17,      1));
        vecs.push_back(mk(1, 16, 32'h16,      0, 0, 0,            0, 0, 0, 13,  0, 1, 1, 13, 32'hD13,     1));
        vecs.push_back(mk(1, 16, 32'h16,      0, 0, 0,            0, 0, 0, 13,  1, 0, 1, 16, 32'h16,      0));

        for (int i = 0; i < vecs.size(); i++) begin
            next_cycle();
            drive(vecs[i].exv, vecs[i].exa, vecs[i].exd, vecs[i].lv, vecs[i].la, vecs[i].ld,
                  vecs[i].li, vecs[i].lia, vecs[i].ra, vecs[i].rb);
            #3;
            chk($sformatf("v%0d_ex_ready", i), {31'b0, ex_ready_o}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("v%0d_hazard", i),   {31'b0, hazard_o},   {31'b0, vecs[i].e_haz});
            chk($sformatf("v%0d_we", i),       {31'b0, rf_we_o},    {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_busy", i),     {31'b0, busy_o},     {31'b0, vecs[i].e_busy});
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_waddr", i), {27'b0, rf_waddr_o}, {27'b0, vecs[i].e_wa});
                chk($sformatf("v%0d_wdata", i), rf_wdata_o, vecs[i].e_wd);
            end
        end

        // Asynchronous reset while a write is held and x4 is pending
        next_cycle();
        drive(1, 20, 32'h20, 1, 21, 32'h21, 1, 4, 0, 0);
        #3;
        chk("rstmid_lsu_waddr", {27'b0, rf_waddr_o}, 32'd21);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 20);
        #1;
        chk("rstmid_pre_hazard", {31'b0, hazard_o}, 32'd1);
        chk("rstmid_pre_busy",   {31'b0, busy_o},   32'd1);
        chk("rstmid_pre_drain",  {27'b0, rf_waddr_o}, 32'd20);
        rst_n = 1'b0;
        #1;
        chk("rstmid_hazard", {31'b0, hazard_o}, 32'd0);
        chk("rstmid_busy",   {31'b0, busy_o},   32'd0);
        chk("rstmid_we",     {31'b0, rf_we_o},  32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        next_cycle();
        #2;
        chk("rstrel_we",     {31'b0, rf_we_o},  32'd0);
        chk("rstrel_busy",   {31'b0, busy_o},   32'd0);
        chk("rstrel_hazard", {31'b0, hazard_o}, 32'd0);

        // RV32E: address 17 aliases x1
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 17, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("e_hazard_x1",  {31'b0, hazard_e}, 32'd1);
        chk("e_busy",       {31'b0, busy_e},   32'd1);
        chk("std_hazard_x1", {31'b0, hazard_o}, 32'd0);
        raddr_a_i = 5'd17;
        #1;
        chk("std_hazard_x17", {31'b0, hazard_o}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 1, 17, 32'h1717, 0, 0, 1, 0);
        #1;
        chk("e_lsu_we", {31'b0, rf_we_e}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("e_hazard_clr", {31'b0, hazard_e}, 32'd0);
        chk("e_busy_clr",   {31'b0, busy_e},   32'd0);
        chk("std_busy_clr", {31'b0, busy_o},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
